memory_stage: RTL

MEM stage of the 5-stage pipeline. It sits directly downstream of execute, fed by the EX/MEM register outputs: the ALU result is the byte address and registro_2 is the store data. It performs byte/half/word loads and stores on an internal data memory with configurable multi-cycle latency, stalls upstream while busy, and owns the MEM/WB pipeline register.

---
 rtl/mem_pkg.sv | 44 ++++
 rtl/memory_stage_if.sv | 35 +++
 rtl/data_memory.sv | 19 +
 rtl/memory_stage.sv | 102 ++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: size encodings, FSM states, request record and byte-lane helpers for the MEM stage.
package mem_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic [31:0] data;
        logic        read;
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic        reg_write;
        logic        mem_to_reg;
        logic [4:0]  rd;
    } req_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        return size == SIZE_BYTE ? 4'b0001 << off :
               size == SIZE_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    // size 2'b11 falls in with word because only bit 1 is tested
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == SIZE_HALF && off[0]) || (size[1] && off != 2'b00);
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] data);
        return size == SIZE_BYTE ? {4{data[7:0]}} :
               size == SIZE_HALF ? {2{data[15:0]}} : data;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] off, input logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        return size == SIZE_BYTE ? {{24{~uns & sh[7]}}, sh[7:0]} :
               size == SIZE_HALF ? {{16{~uns & sh[15]}}, sh[15:0]} : word;
    endfunction
endpackage

// File: rtl/memory_stage_if.sv
// memory_stage_if: EX/MEM inputs, stall back-pressure and MEM/WB outputs of the memory stage.
interface memory_stage_if;
    logic        valid_in;
    logic [31:0] result;
    logic [31:0] registro_2;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        reg_write_in;
    logic        mem_to_reg_in;
    logic [4:0]  rd_in;
    logic        stall;
    logic        valid_out;
    logic [31:0] read_data;
    logic [31:0] alu_result_out;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic        mem_to_reg_out;
    logic        misaligned;

    modport slave (
        input  valid_in, result, registro_2, mem_read, mem_write, mem_size, mem_unsigned,
               reg_write_in, mem_to_reg_in, rd_in,
        output stall, valid_out, read_data, alu_result_out, rd_out, reg_write_out,
               mem_to_reg_out, misaligned
    );

    modport master (
        output valid_in, result, registro_2, mem_read, mem_write, mem_size, mem_unsigned,
               reg_write_in, mem_to_reg_in, rd_in,
        input  stall, valid_out, read_data, alu_result_out, rd_out, reg_write_out,
               mem_to_reg_out, misaligned
    );
endinterface

// File: rtl/data_memory.sv
// data_memory: word-organised RAM with per-byte write enables, synchronous write, asynchronous read.
module data_memory #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [3:0]            we,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);
    logic [31:0] ram [2**ADDR_WIDTH];

    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++)
            if (we[i]) ram[addr][8*i +: 8] <= wdata[8*i +: 8];
    end

    assign rdata = ram[addr];
endmodule

// File: rtl/memory_stage.sv
// memory_stage: multi-cycle load/store stage with stall generation and the MEM/WB pipeline register.
module memory_stage
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic           clock,
    input  logic           reset,
    memory_stage_if.slave  bus
);
    localparam int CW = $clog2(LATENCY + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    req_t            req_q, req_d, live, cur;
    logic            mem_req, commit, mis;
    logic [3:0]      we;
    logic [31:0]     mem_rdata;
    logic            valid_q, valid_d, rw_q, rw_d, m2r_q, m2r_d, mis_q, mis_d;
    logic [31:0]     rdata_q, rdata_d, alu_q, alu_d;
    logic [4:0]      rd_q, rd_d;

    assign live = '{valid: bus.valid_in, result: bus.result, data: bus.registro_2,
                    read: bus.mem_read, write: bus.mem_write, size: bus.mem_size,
                    uns: bus.mem_unsigned, reg_write: bus.reg_write_in,
                    mem_to_reg: bus.mem_to_reg_in, rd: bus.rd_in};
    assign mem_req = live.valid & (live.read | live.write);
    // once busy, the captured request drives everything so upstream may change its inputs
    assign cur = state_q == BUSY ? req_q : live;

    data_memory #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .clock (clock),
        .addr  (cur.result[ADDR_WIDTH+1:2]),
        .we    (we),
        .wdata (store_data(cur.size, cur.data)),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
            alu_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            rw_q    <= rw_d;
            m2r_q   <= m2r_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        if (state_q == IDLE && mem_req && LATENCY > 1) begin
            state_d = BUSY;
            cnt_d   = CW'(LATENCY - 1);
            req_d   = live;
        end else if (state_q == BUSY) begin
            cnt_d   = cnt_q - CW'(1);
            state_d = cnt_q == CW'(1) ? IDLE : BUSY;
        end
    end

    always_comb begin
        commit    = state_q == BUSY ? cnt_q == CW'(1) : (!mem_req || LATENCY == 1);
        mis       = cur.valid & (cur.read | cur.write) & is_misaligned(cur.size, cur.result[1:0]);
        we        = commit && cur.valid && cur.write && !mis ? lane_mask(cur.size, cur.result[1:0]) : 4'b0000;
        bus.stall = (state_q == IDLE && mem_req && LATENCY > 1) || (state_q == BUSY && cnt_q > CW'(1));
        valid_d   = commit & cur.valid;
        rw_d      = commit & cur.valid & cur.reg_write;
        m2r_d     = commit & cur.mem_to_reg;
        mis_d     = commit & mis;
        alu_d     = commit ? cur.result : '0;
        rd_d      = commit ? cur.rd : '0;
        rdata_d   = commit && cur.valid && cur.read && !cur.write && !mis ?
                    extend(mem_rdata, cur.size, cur.result[1:0], cur.uns) : '0;
    end

    assign bus.valid_out      = valid_q;
    assign bus.reg_write_out  = rw_q;
    assign bus.mem_to_reg_out = m2r_q;
    assign bus.misaligned     = mis_q;
    assign bus.read_data      = rdata_q;
    assign bus.alu_result_out = alu_q;
    assign bus.rd_out         = rd_q;
endmodule
